// File: rtl/byte_serial_adder_seq.sv
// -----------------------------------------------------------------------------
// byte_serial_adder_seq
//
// Purpose:
//   Sequencer in front of a single 8-bit ripple-carry adder stage. It takes a
//   byte-serial stream of operand pairs (least-significant byte first), adds
//   each pair together with a registered carry, chains the carry across the
//   beats of a word and emits registered sum bytes on a valid/ready stream.
//   A word is at most MAX_BYTES beats long; a word that reaches MAX_BYTES
//   beats without in_last is terminated by force and flagged in err.
//
// Parameters:
//   MAX_BYTES  maximum beats per word before a forced termination
//   CNT_W      byte-counter width, must satisfy 2**CNT_W > MAX_BYTES
//
// Optional feature (macro BYTE_SERIAL_SUB_EN):
//   Adds input in_sub. It is sampled on the first beat of each word and held
//   for the whole word. When set, the B byte is inverted and the first-beat
//   carry-in is 1, so the word computes A-B in two's complement and
//   out_cout=1 means "no borrow". Without the macro the block only adds.
//
// Ports:
//   clk        in   clock, all logic on the rising edge
//   rst_n      in   synchronous active-low reset
//   in_valid   in   operand beat valid
//   in_ready   out  block can accept a beat this cycle
//   in_a       in   [7:0] operand A byte
//   in_b       in   [7:0] operand B byte
//   in_first   in   beat is the LSB of a new word
//   in_last    in   beat is the MSB of the word
//   in_sub     in   subtract select (only with BYTE_SERIAL_SUB_EN)
//   out_valid  out  sum beat valid
//   out_ready  in   downstream accepts the sum beat
//   out_sum    out  [7:0] sum byte
//   out_last   out  sum beat is the final byte of the word
//   out_cout   out  word carry-out, only non-zero when out_last=1
//   err        out  sticky protocol error flag, cleared only by reset
// -----------------------------------------------------------------------------
module byte_serial_adder_seq #(
    parameter int unsigned MAX_BYTES = 16,
    parameter int unsigned CNT_W     = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_a,
    input  logic [7:0] in_b,
    input  logic       in_first,
    input  logic       in_last,
`ifdef BYTE_SERIAL_SUB_EN
    input  logic       in_sub,
`endif
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_sum,
    output logic       out_last,
    output logic       out_cout,
    output logic       err
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    // ---------------------------------------------------------------------
    // State and output registers
    // ---------------------------------------------------------------------
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic             r_err;
    logic             r_out_valid;
    logic [7:0]       r_out_sum;
    logic             r_out_last;
    logic             r_out_cout;

    // Next-state values
    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_carry_nxt;
    logic             w_err_nxt;
    logic             w_out_valid_nxt;
    logic [7:0]       w_out_sum_nxt;
    logic             w_out_last_nxt;
    logic             w_out_cout_nxt;

    // Datapath / decode
    logic             w_accept;
    logic             w_first_beat;
    logic             w_sub;
    logic [7:0]       w_b;
    logic             w_cin;
    logic [8:0]       w_sum9;
    logic [CNT_W-1:0] w_cnt_beat;
    logic             w_overflow;
    logic             w_word_end;
    logic             w_proto_err;

    // Single output register without a skid buffer: a new beat can only be
    // taken when the register is empty or is being drained this cycle.
    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    // A beat starts a fresh word when nothing is in flight, or when it is
    // explicitly marked first (which also restarts a word already running).
    assign w_first_beat = (r_state == S_IDLE) || in_first;

`ifdef BYTE_SERIAL_SUB_EN
    logic r_sub;
    logic w_sub_nxt;

    // The operation is latched on the first beat; later beats of the same
    // word ignore in_sub.
    assign w_sub     = w_first_beat ? in_sub : r_sub;
    assign w_sub_nxt = (w_accept && w_first_beat) ? in_sub : r_sub;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sub <= 1'b0;
        end else begin
            r_sub <= w_sub_nxt;
        end
    end
`else
    assign w_sub = 1'b0;
`endif

    // Subtraction is A + ~B + 1: inverted B, and the "+1" enters as the
    // carry-in of the first beat. Later beats take the chained carry.
    assign w_b    = w_sub ? ~in_b : in_b;
    assign w_cin  = w_first_beat ? w_sub : r_carry;
    assign w_sum9 = {1'b0, in_a} + {1'b0, w_b} + {8'd0, w_cin};

    // Beat count including the current beat.
    assign w_cnt_beat = w_first_beat ? CNT_W'(1) : (r_cnt + CNT_W'(1));

    // Hitting the size limit without in_last closes the word by force.
    assign w_overflow = !in_last && (w_cnt_beat == CNT_W'(MAX_BYTES));
    assign w_word_end = in_last || w_overflow;

    // Protocol violations: a word not opened with in_first, a restart in
    // the middle of a word, or a word that ran past MAX_BYTES.
    assign w_proto_err = ((r_state == S_IDLE) && !in_first) ||
                         ((r_state == S_BUSY) &&  in_first) ||
                         w_overflow;

    // ---------------------------------------------------------------------
    // Next-state / next-output logic
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_carry_nxt     = r_carry;
        w_err_nxt       = r_err;
        w_out_valid_nxt = r_out_valid;
        w_out_sum_nxt   = r_out_sum;
        w_out_last_nxt  = r_out_last;
        w_out_cout_nxt  = r_out_cout;

        // Draining the output register; overwritten below if a new beat
        // is loaded in the same cycle.
        if (r_out_valid && out_ready) begin
            w_out_valid_nxt = 1'b0;
        end

        if (w_accept) begin
            w_out_valid_nxt = 1'b1;
            w_out_sum_nxt   = w_sum9[7:0];
            w_out_last_nxt  = w_word_end;
            w_out_cout_nxt  = w_word_end ? w_sum9[8] : 1'b0;

            if (w_proto_err) begin
                w_err_nxt = 1'b1;
            end

            if (w_word_end) begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_carry_nxt = 1'b0;
            end else begin
                w_state_nxt = S_BUSY;
                w_cnt_nxt   = w_cnt_beat;
                w_carry_nxt = w_sum9[8];
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_last  <= 1'b0;
            r_out_cout  <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_carry     <= w_carry_nxt;
            r_err       <= w_err_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_sum   <= w_out_sum_nxt;
            r_out_last  <= w_out_last_nxt;
            r_out_cout  <= w_out_cout_nxt;
        end
    end

    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_last  = r_out_last;
    assign out_cout  = r_out_cout;
    assign err       = r_err;

endmodule

// File: tb/tb_byte_serial_adder_seq.sv
// -----------------------------------------------------------------------------
// tb_byte_serial_adder_seq
//
// Bench for byte_serial_adder_seq, built with MAX_BYTES=4 so that forced
// word termination is reachable. Expected sum bytes come from whole-word
// integer arithmetic on the operand bytes seen so far in the word.
// With BYTE_SERIAL_SUB_EN defined the in_sub port is exercised as well.
// -----------------------------------------------------------------------------
module tb_byte_serial_adder_seq;

    localparam int unsigned TB_MAX = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       in_first;
    logic       in_last;
    logic       tb_sub;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_sum;
    logic       out_last;
    logic       out_cout;
    logic       err;

    always #5 clk = ~clk;

    byte_serial_adder_seq #(
        .MAX_BYTES(TB_MAX),
        .CNT_W    (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_first (in_first),
        .in_last  (in_last),
`ifdef BYTE_SERIAL_SUB_EN
        .in_sub   (tb_sub),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_last (out_last),
        .out_cout (out_cout),
        .err      (err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------------------------------------------------------------
    // Reference model: whole-word arithmetic on accumulated operands
    // ---------------------------------------------------------------------
    typedef struct {
        logic [7:0] s;
        logic       l;
        logic       c;
    } exp_t;

    exp_t              q[$];
    bit                m_in_word;
    bit                m_err;
    bit                m_sub;
    int                m_k;
    longint unsigned   m_a;
    longint unsigned   m_b;

    task automatic model_reset();
        q.delete();
        m_in_word = 0;
        m_err     = 0;
        m_sub     = 0;
        m_k       = 0;
        m_a       = 0;
        m_b       = 0;
    endtask

    task automatic model_beat(input logic [7:0] a, input logic [7:0] b,
                              input bit f, input bit l, input bit sub);
        longint unsigned mask;
        longint unsigned res;
        bit              cout;
        bit              fin;
        exp_t            e;
        int              width;
        if (!m_in_word && !f) m_err = 1;
        if (m_in_word && f)   m_err = 1;
        if (!m_in_word || f) begin
            m_a   = 0;
            m_b   = 0;
            m_k   = 0;
            m_sub = sub;
        end
        m_a   = m_a | (longint'(a) << (8 * m_k));
        m_b   = m_b | (longint'(b) << (8 * m_k));
        width = 8 * (m_k + 1);
        mask  = (64'd1 << width) - 64'd1;
        if (m_sub) begin
            res  = (m_a - m_b) & mask;
            cout = (m_a >= m_b);
        end else begin
            res  = m_a + m_b;
            cout = res[width];
        end
        fin = l || ((m_k + 1) == int'(TB_MAX));
        if (fin && !l) m_err = 1;
        e.s = 8'((res >> (8 * m_k)) & 64'hFF);
        e.l = fin;
        e.c = fin ? cout : 1'b0;
        q.push_back(e);
        if (fin) begin
            m_in_word = 0;
        end else begin
            m_in_word = 1;
            m_k++;
        end
    endtask

    // One clock cycle: check the DUT against the model mid-cycle, advance
    // the model for whatever transfers happen at the coming edge, then step
    // past that edge.
    task automatic cycle(output bit acc);
        bit exp_rdy;
        @(negedge clk);
        chk("out_valid", out_valid, q.size() != 0);
        if (q.size() != 0) begin
            chk("out_sum",  out_sum,  q[0].s);
            chk("out_last", out_last, q[0].l);
            chk("out_cout", out_cout, q[0].c);
        end
        exp_rdy = (q.size() == 0) || out_ready;
        chk("in_ready", in_ready, exp_rdy);
        chk("err", err, m_err);
        acc = 0;
        if (!rst_n) begin
            model_reset();
        end else begin
            if (q.size() != 0 && out_ready) void'(q.pop_front());
            if (in_valid && exp_rdy) begin
                acc = 1;
                model_beat(in_a, in_b, in_first, in_last, tb_sub);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [7:0] a, input logic [7:0] b,
                             input bit f, input bit l, input bit sub);
        bit acc;
        acc      = 0;
        in_valid = 1;
        in_a     = a;
        in_b     = b;
        in_first = f;
        in_last  = l;
        tb_sub   = sub;
        for (int i = 0; i < 20 && !acc; i++) cycle(acc);
        if (!acc) chk("accept_timeout", 0, 1);
        in_valid = 0;
    endtask

    task automatic idle_cycles(input int n);
        bit acc;
        in_valid = 0;
        for (int i = 0; i < n; i++) cycle(acc);
    endtask

    task automatic do_reset();
        bit acc;
        rst_n    = 0;
        in_valid = 0;
        cycle(acc);
        rst_n = 1;
    endtask

    // ---------------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------------
    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       f;
        logic       l;
        logic [7:0] s;
        logic       lst;
        logic       co;
    } vec_t;

    vec_t tbl[8];

    initial begin
        bit acc;

        tbl[0] = '{8'h98, 8'hAA, 1'b1, 1'b1, 8'h42, 1'b1, 1'b1};
        tbl[1] = '{8'hFF, 8'h01, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[2] = '{8'h12, 8'h00, 1'b0, 1'b1, 8'h13, 1'b1, 1'b0};
        tbl[3] = '{8'h01, 8'h01, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0};
        tbl[4] = '{8'h80, 8'h80, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[5] = '{8'h7F, 8'h00, 1'b0, 1'b0, 8'h80, 1'b0, 1'b0};
        tbl[6] = '{8'hFF, 8'hFF, 1'b0, 1'b1, 8'hFE, 1'b1, 1'b1};
        tbl[7] = '{8'hFF, 8'h01, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1};

        rst_n     = 0;
        in_valid  = 0;
        in_a      = '0;
        in_b      = '0;
        in_first  = 0;
        in_last   = 0;
        tb_sub    = 0;
        out_ready = 1;
        model_reset();
        @(posedge clk);
        #1;
        cycle(acc);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum",   out_sum,   0);
        chk("rst_out_last",  out_last,  0);
        chk("rst_out_cout",  out_cout,  0);
        chk("rst_err",       err,       0);
        rst_n = 1;

        // Back-to-back table beats with constant expectations
        for (int i = 0; i < 8; i++) begin
            in_valid = 1;
            in_a     = tbl[i].a;
            in_b     = tbl[i].b;
            in_first = tbl[i].f;
            in_last  = tbl[i].l;
            cycle(acc);
            chk("tbl_accept",   acc,       1);
            chk("tbl_valid",    out_valid, 1);
            chk("tbl_sum",      out_sum,   tbl[i].s);
            chk("tbl_last",     out_last,  tbl[i].lst);
            chk("tbl_cout",     out_cout,  tbl[i].co);
        end
        idle_cycles(2);
        chk("tbl_err", err, 0);

        // Backpressure: 4-byte word 0x04030201 + 0x10203040
        out_ready = 0;
        send_beat(8'h01, 8'h40, 1, 0, 0);
        in_valid = 1;
        in_a     = 8'h02;
        in_b     = 8'h30;
        in_first = 0;
        in_last  = 0;
        for (int i = 0; i < 3; i++) begin
            cycle(acc);
            chk("bp_no_accept", acc,      0);
            chk("bp_in_ready",  in_ready, 0);
            chk("bp_hold_sum",  out_sum,  8'h41);
        end
        out_ready = 1;
        send_beat(8'h02, 8'h30, 0, 0, 0);
        send_beat(8'h03, 8'h20, 0, 0, 0);
        send_beat(8'h04, 8'h10, 0, 1, 0);
        chk("bp_final_sum",  out_sum,  8'h14);
        chk("bp_final_last", out_last, 1);
        idle_cycles(2);

        // Overflow: 5 beats, no in_last
        send_beat(8'h10, 8'h01, 1, 0, 0);
        send_beat(8'h20, 8'h01, 0, 0, 0);
        send_beat(8'h30, 8'h01, 0, 0, 0);
        chk("ov_no_err_yet", err, 0);
        send_beat(8'h40, 8'h01, 0, 0, 0);
        chk("ov_sum4",  out_sum,  8'h41);
        chk("ov_last4", out_last, 1);
        chk("ov_err",   err,      1);
        send_beat(8'hF0, 8'h10, 0, 0, 0);
        chk("ov_sum5",  out_sum,  8'h00);
        chk("ov_last5", out_last, 0);
        chk("ov_cout5", out_cout, 0);
        idle_cycles(1);

        // Reset mid-word
        send_beat(8'hFF, 8'hFF, 1, 0, 0);
        do_reset();
        chk("mr_valid", out_valid, 0);
        chk("mr_err",   err,       0);
        send_beat(8'h01, 8'h01, 1, 1, 0);
        chk("mr_sum",   out_sum,  8'h02);
        chk("mr_cout",  out_cout, 0);
        chk("mr_last",  out_last, 1);

        // Missing in_first from idle
        send_beat(8'h03, 8'h04, 0, 1, 0);
        chk("nf_sum", out_sum, 8'h07);
        chk("nf_err", err,     1);
        idle_cycles(1);

        // Restart inside a word
        do_reset();
        send_beat(8'hFF, 8'h01, 1, 0, 0);
        send_beat(8'hFF, 8'h01, 1, 1, 0);
        chk("rs_sum",  out_sum,  8'h00);
        chk("rs_cout", out_cout, 1);
        chk("rs_err",  err,      1);
        idle_cycles(1);

`ifdef BYTE_SERIAL_SUB_EN
        do_reset();
        send_beat(8'h05, 8'h07, 1, 1, 1);
        chk("sub_sum",  out_sum,  8'hFE);
        chk("sub_cout", out_cout, 0);
        send_beat(8'h00, 8'h01, 1, 0, 1);
        send_beat(8'h01, 8'h00, 0, 1, 0);
        chk("sub2_sum",  out_sum,  8'h00);
        chk("sub2_cout", out_cout, 1);
        idle_cycles(1);
`endif

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            in_a      = 8'($urandom);
            in_b      = 8'($urandom);
            in_first  = m_in_word ? ($urandom_range(0, 19) == 0)
                                  : ($urandom_range(0, 9) != 0);
            in_last   = ($urandom_range(0, 9) < 3);
`ifdef BYTE_SERIAL_SUB_EN
            tb_sub    = $urandom_range(0, 1) == 1;
`endif
            if (i == 300) rst_n = 0;
            cycle(acc);
            rst_n = 1;
        end
        out_ready = 1;
        idle_cycles(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/byte_serial_adder_seq.md
Name: byte_serial_adder_seq

Overview:
- Sequencer that sits directly upstream of the 8-bit ripple-carry adder stage.
- Consumes a byte-serial stream of operand pairs, least-significant byte first, and feeds each pair plus a registered carry into one 8-bit add.
- Chains the carry across beats and emits registered sum bytes on a valid/ready stream.
- Lets one 8-bit adder perform arbitrary multi-byte additions, up to MAX_BYTES bytes per word.

Parameters:
- MAX_BYTES, 16, maximum beats per word before a forced termination.
- CNT_W, 5, byte-counter width; must satisfy 2^CNT_W > MAX_BYTES.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block can accept a beat this cycle
- in_a  input  8  operand A byte
- in_b  input  8  operand B byte
- in_first  input  1  beat is the LSB of a new word
- in_last  input  1  beat is the MSB of the word
- out_valid  output  1  sum beat valid
- out_ready  input  1  downstream accepts sum beat
- out_sum  output  8  sum byte
- out_last  output  1  sum beat is the final byte of the word
- out_cout  output  1  word carry-out; meaningful only when out_last=1, else 0
- err  output  1  sticky protocol error flag; cleared only by reset

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset values (rst_n=0 at a clock edge):
  - out_valid=0, out_sum=0, out_last=0, out_cout=0, err=0.
  - Carry register=0, byte counter=0, FSM=IDLE.
  - Any partial word is discarded.
- Handshake:
  - in_ready = !out_valid || out_ready (single output register, no skid buffer).
  - Beat accepted when in_valid && in_ready.
  - Output beat transfers when out_valid && out_ready.
  - While out_valid=1 and out_ready=0, out_sum/out_last/out_cout are held stable.
- Arithmetic per accepted beat:
  - cin = 0 if FSM=IDLE or in_first=1; otherwise cin = carry_q.
  - {c9, s} = in_a + in_b + cin, computed as a 9-bit result.
  - out_sum <= s; carry_q <= c9.
- Latency: 1 cycle from accepted beat to out_valid.
  - Full throughput of 1 beat/cycle while out_ready=1.
- FSM:
  - IDLE: accepted beat → BUSY, counter=1. If in_first=0, set err, still process with cin=0. If in_last=1 on the same beat (single-byte word), stay IDLE, out_last=1, out_cout=c9, carry_q cleared.
  - BUSY: accepted beat increments the counter.
    - in_first=1 → set err, restart word with cin=0, counter=1.
    - in_last=1 → out_last=1, out_cout=c9, carry_q<=0, counter<=0, → IDLE.
  - Overflow: an accepted beat that makes counter==MAX_BYTES without in_last forces out_last=1, out_cout=c9, sets err, → IDLE.
- out_cout=0 on every non-last beat.
- Simultaneous in_first and in_last on one beat: single-byte word, no error.
- Reset mid-word: all state cleared; the next beat must carry in_first, else err is set.

Optional Feature:
- Macro: BYTE_SERIAL_SUB_EN.
- Defined:
  - Adds input port in_sub (1 bit), sampled on each word's first beat and held for the whole word.
  - When held in_sub=1: B byte is inverted and the first-beat cin=1, giving A−B in two's complement.
  - out_cout=1 means no borrow.
- Undefined: port absent, addition only.

Test Plan:
- Single beat A=0x98, B=0xAA, first=last=1 → out_sum=0x42, out_last=1, out_cout=1, err=0, one cycle later.
- Two-byte 0x12FF+0x0001: beats (FF,01,first) then (12,00,last) → sums 0x00 (cout 0), then 0x13 with out_last=1, out_cout=0.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, out_sum held, no beat lost; 4-beat word output stays in order.
- Reset mid-word after beat (FF,FF,first): rst_n=0 for one cycle → out_valid=0, carry cleared; next (01,01,first,last) gives 0x02, cout 0.
- Overflow with MAX_BYTES=4: 5 beats, none with in_last → 4th output has out_last=1, err=1; 5th beat handled from IDLE with cin=0.
- BYTE_SERIAL_SUB_EN: in_sub=1, A=0x05, B=0x07, single beat → out_sum=0xFE, out_cout=0.
